glip_stream_arbiter: RTL and testbench
======================================

# glip_stream_arbiter

Round-robin arbiter that shares the single GLIP byte-stream output FIFO (`fifo_out_*` of the UART backend) between N independent logic-side producers (loopback path, pattern generator, measurement reporter, ...). It grants one requester at a time for a bounded burst, muxes its data and valid/ready handshake onto the shared port, and rotates priority so no producer starves. It sits between the board-level producers and the backend toplevel, in the logic clock domain.

## Interface

Parameters:
- `N`, 4, number of requesters, 2..8
- `WIDTH`, 8, data width per stream word
- `MAX_BURST`, 16, maximum transfers per grant, ≥1

Ports:
- `clk`  in  1  logic clock; all state on rising edge
- `rstn`  in  1  reset; asynchronous, active-low
- `req_data`  in  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- `req_valid`  in  N  requester i has a word
- `req_ready`  out  N  word of requester i accepted when `req_valid[i] & req_ready[i]`
- `out_data`  out  WIDTH  to backend `fifo_out_data`
- `out_valid`  out  1  to backend `fifo_out_valid`
- `out_ready`  in  1  from backend `fifo_out_ready`
- `grant`  out  N  one-hot current owner, all-zero when idle
- `active`  out  1  high while in GRANT

## Operation

- States: IDLE, GRANT. Registers: `state`, `grant`, `last` (index of last owner, $clog2(N) bits), `count` ($clog2(MAX_BURST+1) bits).
- IDLE: `out_valid`=0, all `req_ready`=0. If any `req_valid`, pick first set bit searching from `last+1` upward with wrap at N-1→0; next edge: `grant` = one-hot(pick), `count`=0, state GRANT. No request: stay.
- GRANT (owner g): `out_data` = `req_data[g]`, `out_valid` = `req_valid[g]`, `req_ready[g]` = `out_ready`, all other `req_ready`=0 (combinational from registered `grant`).
- Transfer = `out_valid & out_ready`; each transfer increments `count`.
- Release (next edge: state IDLE, `grant`=0, `last`=g, `count`=0) when either:
  - transfer occurs with `count == MAX_BURST-1` (burst exhausted), or
  - `req_valid[g]`=0 in a GRANT cycle (owner drained).
- Requesters other than g changing `req_valid` during GRANT has no effect.
- Requester must not drop `req_valid` while its word is unaccepted except to end its stream; arbiter treats the drop as release, never as error.
- Reset (`rstn` low, any time incl. mid-burst): state IDLE, `grant`=0, `active`=0, `out_valid`=0, `req_ready`=0, `count`=0, `last`=N-1 (requester 0 wins first). In-flight word is not transferred.

## Timing

- Arbitration latency: `req_valid` seen in IDLE at cycle t → `grant`/`active`/`out_valid` at t+1.
- Throughput within grant: one word/cycle while `out_ready`=1.
- One idle bubble between grants: release after transfer at t → IDLE at t+1 → next owner's `out_valid` at t+2.
- `out_ready`=0 stalls: `count` holds, grant held indefinitely while owner's `req_valid` stays high.
- `out_data`/`out_valid`/`req_ready` are combinational through a single N:1 mux; no path from `out_ready` to `out_valid`.

## Structure

- Shared package/header `glip_arbiter_pkg`: state encoding constants (IDLE=0, GRANT=1), `clog2` helper.
- One sub-module `glip_rr_select`: combinational, inputs `req` [N], `last`; outputs `pick` index and `any`. Used only in IDLE.
- Top holds FSM, counter, muxes.

## Test plan

- Single requester 2 streams 40 words 0x00..0x27 with `out_ready`=1 → three grants of 16,16,8 words, order preserved, one bubble after words 15 and 31.
- All four requesters valid continuously after reset, MAX_BURST=16 → grants 0,1,2,3,0 in that order, each exactly 16 words.
- Requester 1 valid for 5 words then drops, requester 3 waiting → grant 1 ends after 5 words, `grant`=4'b1000 two cycles after last transfer of 1.
- `out_ready` held 0 for 10 cycles mid-burst → `out_data` stable, `count` unchanged, no `req_ready` pulse; resumes with correct next word.
- `rstn` asserted during burst at count 7 → next cycle outputs all zero, after release requester 0 granted first regardless of prior owner.
- Requester 2 only, `last`=2 → requester 2 regranted (wrap search returns to itself), no starvation.

Source files
------------

// File: rtl/glip_arbiter_pkg.sv
// Shared definitions for the GLIP stream arbiter: FSM state encoding and a
// constant-evaluable ceiling-log2 helper for sizing index and counter fields.
package glip_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2, clamped to 1 so a field sized with it is never zero-width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage : glip_arbiter_pkg

// File: rtl/glip_rr_select.sv
// Round-robin pick: first set request searching upward from last+1, wrapping
// at N-1 to 0, so the previous owner is considered last.
module glip_rr_select
    import glip_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    int idx;

    // NOTE: every output gets a default before the search loop; otherwise a
    // path that never assigns it would infer a latch.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = IDX_W'(idx);
            end
        end
    end

endmodule : glip_rr_select

// File: rtl/glip_stream_arbiter.sv
// Round-robin arbiter sharing one GLIP byte-stream output between N producers,
// granting bounded bursts and inserting one idle cycle between owners.
module glip_stream_arbiter
    import glip_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       grant,
    output logic               active
);

    localparam int IDX_W = clog2(N);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [N-1:0]     ONE_HOT0  = N'(1);

    arb_state_e       state_q;
    logic [N-1:0]     grant_q;
    logic [N-1:0]     grant_d;
    logic [IDX_W-1:0] last_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic [IDX_W-1:0] owner_idx;
    logic             owner_valid;
    logic             xfer;
    logic             burst_done;
    logic             release_grant;

    glip_rr_select #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req  (req_valid),
        .last (last_q),
        .pick (pick),
        .any  (any_req)
    );

    // AND-OR mux keyed by the registered one-hot grant; an all-zero grant in
    // IDLE forces data, valid and ready low without a separate state decode.
    always_comb begin
        out_data    = '0;
        owner_valid = 1'b0;
        owner_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                out_data    = out_data | req_data[i*WIDTH +: WIDTH];
                owner_valid = owner_valid | req_valid[i];
                owner_idx   = IDX_W'(i);
            end
        end
    end

    assign out_valid = owner_valid;
    assign req_ready = grant_q & {N{out_ready}};
    assign grant     = grant_q;
    assign active    = (state_q == ST_GRANT);

    assign xfer          = out_valid & out_ready;
    assign burst_done    = xfer && (count_q == LAST_BEAT);
    assign release_grant = (state_q == ST_GRANT) && (!owner_valid || burst_done);

    assign grant_d = ONE_HOT0 << pick;
    assign count_d = count_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_INIT;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_GRANT;
                        grant_q <= grant_d;
                        count_q <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        last_q  <= owner_idx;
                        count_q <= '0;
                    end else if (xfer) begin
                        count_q <= count_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    count_q <= '0;
                end
            endcase
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(grant_q));

    a_grant_matches_state: assert property (@(posedge clk) disable iff (!rstn)
        (grant_q != '0) == (state_q == ST_GRANT));

    a_count_bounded: assert property (@(posedge clk) disable iff (!rstn)
        count_q <= LAST_BEAT);

endmodule : glip_stream_arbiter

// File: tb/tb_glip_stream_arbiter.sv
// Scoreboard bench for glip_stream_arbiter: producers are modelled as word
// queues, expected (owner, data) pairs are queued up front and a monitor pops them.
module tb_glip_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;

    typedef struct packed {
        logic [2:0]   owner;
        logic [W-1:0] data;
    } exp_t;

    logic           clk;
    logic           rstn;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           active;

    logic [W-1:0] src_q [N][$];
    exp_t         exp_q [$];
    int           xfer_cyc [$];

    int errors;
    int checks;
    int cyc;
    int xfer_total;
    int xfer_base;

    glip_stream_arbiter #(
        .N         (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Producer model: a word leaves its queue only after a handshake seen at negedge.
    logic [N-1:0] fire;
    always begin
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            req_valid[i] = (src_q[i].size() > 0);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    end

    // Monitor: every accepted output word is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        logic [N-1:0] one;
        cyc++;
        if (rstn && out_valid && out_ready) begin
            xfer_total++;
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_xfer: got data 0x%0h grant 0x%0h, expected no transfer",
                         out_data, grant);
            end else begin
                e   = exp_q.pop_front();
                one = N'(1);
                check("xfer_data", 32'(out_data), 32'(e.data));
                check("xfer_owner", 32'(grant), 32'(one << e.owner));
            end
        end
    end

    task automatic load_src(input int i, input logic [W-1:0] base, input int n);
        for (int j = 0; j < n; j++) src_q[i].push_back(base + W'(j));
    endtask

    task automatic exp_push(input int i, input logic [W-1:0] base, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.owner = 3'(i);
            e.data  = base + W'(j);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        xfer_base = xfer_total;
        xfer_cyc.delete();
        rstn = 1'b1;
    endtask

    task automatic wait_xfers(input int target, input string name);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (xfer_total - xfer_base >= target) break;
        end
        check(name, 32'(xfer_total - xfer_base), 32'(target));
    endtask

    task automatic wait_drain(input string name);
        int pending;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #2;
            pending = exp_q.size();
            for (int i = 0; i < N; i++) pending += src_q[i].size();
            if (pending == 0) break;
        end
        check(name, 32'(pending), 32'd0);
    endtask

    initial begin
        bit found;
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        xfer_total = 0;
        xfer_base  = 0;
        rstn       = 1'b0;
        out_ready  = 1'b1;
        req_valid  = '0;
        req_data   = '0;

        // Test 1: requester 2 alone streams 40 words -> bursts of 16, 16, 8.
        // Each re-grant wraps the search back to requester 2 itself.
        do_reset();
        load_src(2, 8'h00, 40);
        exp_push(2, 8'h00, 40);
        @(posedge clk);
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        release_reset();
        wait_drain("t1_drain");
        check("t1_xfer_count", 32'(xfer_cyc.size()), 32'd40);
        if (xfer_cyc.size() >= 40) begin
            for (int k = 1; k < 40; k++) begin
                check($sformatf("t1_gap_%0d", k), 32'(xfer_cyc[k] - xfer_cyc[k-1]),
                      (k == 16 || k == 32) ? 32'd2 : 32'd1);
            end
        end

        // Test 2: all four requesters busy -> 16 words each in order 0,1,2,3 then 0..3 again.
        do_reset();
        for (int i = 0; i < N; i++) load_src(i, W'(i * 64), 20);
        for (int i = 0; i < N; i++) exp_push(i, W'(i * 64), 16);
        for (int i = 0; i < N; i++) exp_push(i, W'(i * 64 + 16), 4);
        release_reset();
        wait_drain("t2_drain");

        // Test 3: requester 1 drains after 5 words, requester 3 is waiting.
        do_reset();
        load_src(1, 8'h10, 5);
        load_src(3, 8'h30, 3);
        exp_push(1, 8'h10, 5);
        exp_push(3, 8'h30, 3);
        release_reset();
        wait_xfers(5, "t3_five_words");
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found) begin
                @(posedge clk);
                #2;
                if (grant == 4'b1000) found = 1'b1;
            end
        end
        check("t3_handoff_to_3", 32'(found), 32'd1);
        wait_drain("t3_drain");

        // Test 4: out_ready low for 10 cycles after 4 words of requester 0.
        do_reset();
        load_src(0, 8'h40, 8);
        exp_push(0, 8'h40, 8);
        release_reset();
        wait_xfers(4, "t4_pre_stall");
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            check("t4_stall_data", 32'(out_data), 32'h44);
            check("t4_stall_valid", 32'(out_valid), 32'd1);
            check("t4_stall_ready", 32'(req_ready), 32'd0);
            check("t4_stall_count", 32'(u_dut.count_q), 32'd4);
            check("t4_stall_grant", 32'(grant), 32'b0001);
        end
        out_ready = 1'b1;
        wait_drain("t4_drain");

        // Test 5: reset hits requester 2's burst at count 7; requester 0 wins afterwards.
        do_reset();
        load_src(2, 8'h80, 20);
        exp_push(2, 8'h80, 20);
        release_reset();
        wait_xfers(7, "t5_pre_reset");
        check("t5_count_at_7", 32'(u_dut.count_q), 32'd7);
        rstn = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_active", 32'(active), 32'd0);
        check("t5_rst_req_ready", 32'(req_ready), 32'd0);
        check("t5_rst_count", 32'(u_dut.count_q), 32'd0);
        exp_q.delete();
        load_src(0, 8'hA0, 3);
        exp_push(0, 8'hA0, 3);
        exp_push(2, 8'h87, 13);
        @(posedge clk);
        #2;
        check("t5_rst_hold_valid", 32'(out_valid), 32'd0);
        release_reset();
        wait_drain("t5_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_glip_stream_arbiter
